// File: rtl/mmul_arbiter_if.sv
// Bundle of signals between two matrix-multiply requesters, the arbiter and the
// shared multiplier. Operands and results are flattened row-major, WIDTH bits each.
interface mmul_arbiter_if #(
    parameter int M     = 3,
    parameter int N     = 3,
    parameter int K     = 3,
    parameter int L     = 3,
    parameter int WIDTH = 8
);
    localparam int A_W = M * N * WIDTH;
    localparam int B_W = K * L * WIDTH;
    localparam int C_W = M * L * WIDTH;

    logic           req0_valid;
    logic           req0_ready;
    logic [A_W-1:0] req0_a;
    logic [B_W-1:0] req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [A_W-1:0] req1_a;
    logic [B_W-1:0] req1_b;

    logic           resp0_valid;
    logic           resp0_ready;
    logic [C_W-1:0] resp0_c;
    logic           resp0_invalid;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [C_W-1:0] resp1_c;
    logic           resp1_invalid;

    logic           mm_enable;
    logic [A_W-1:0] mm_a;
    logic [B_W-1:0] mm_b;
    logic [C_W-1:0] mm_c;
    logic           mm_done;
    logic           mm_invalid;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_c, resp0_invalid,
        output resp1_valid, resp1_c, resp1_invalid,
        input  resp0_ready, resp1_ready,
        output mm_enable, mm_a, mm_b,
        input  mm_c, mm_done, mm_invalid
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_c, resp0_invalid,
        input  resp1_valid, resp1_c, resp1_invalid,
        output resp0_ready, resp1_ready,
        input  mm_enable, mm_a, mm_b,
        output mm_c, mm_done, mm_invalid
    );
endinterface

// File: rtl/mmul_arbiter.sv
// Round-robin arbiter granting two requesters one at a time onto a shared matrix
// multiplier, with a run timeout and a drain phase waiting for mm_done to fall.
module mmul_arbiter #(
    parameter int M       = 3,
    parameter int N       = 3,
    parameter int K       = 3,
    parameter int L       = 3,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic           clk,
    input logic           reset,
    mmul_arbiter_if.slave bus
);
    localparam int A_W   = M * N * WIDTH;
    localparam int B_W   = K * L * WIDTH;
    localparam int C_W   = M * L * WIDTH;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [C_W-1:0]   c_q;
    logic             inv_q;
    logic             owner_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic sel;
    logic sel_vld;
    logic accept;
    logic timeout_hit;

    // last_q holds the most recently served requester; ties go to the other one
    always_comb begin
        sel_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_q;
        end else begin
            sel = bus.req1_valid;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        accept          = 1'b0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        bus.mm_enable   = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = sel_vld & ~sel;
                bus.req1_ready = sel_vld & sel;
                if (sel_vld) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.mm_enable = 1'b1;
                if (bus.mm_done || timeout_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                bus.resp0_valid = ~owner_q;
                bus.resp1_valid = owner_q;
                if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.mm_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            inv_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                a_q     <= sel ? bus.req1_a : bus.req0_a;
                b_q     <= sel ? bus.req1_b : bus.req0_b;
                owner_q <= sel;
                last_q  <= sel;
                cnt_q   <= '0;
            end
            // mm_done wins over a timeout landing on the same cycle
            if (state == RUN) begin
                if (bus.mm_done) begin
                    c_q   <= bus.mm_c;
                    inv_q <= bus.mm_invalid;
                end else if (timeout_hit) begin
                    c_q   <= '0;
                    inv_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.mm_a          = a_q;
    assign bus.mm_b          = b_q;
    assign bus.resp0_c       = c_q;
    assign bus.resp1_c       = c_q;
    assign bus.resp0_invalid = inv_q;
    assign bus.resp1_invalid = inv_q;
endmodule
